d_e_pipe_reg: RTL

D/E pipeline register of the 5-stage MIPS core. It sits directly downstream of the register file and D-stage decode.
- Captures the GRF read data (already forwarded in D), the extended immediate, register addresses, instruction and PC at each clock edge.
- Presents these to the E stage.
- Implements bubble insertion on a hazard stall and flush on redirect.
- Tracks per-instruction Tnew and keeps a bubble counter for debug and performance checks.

---
 rtl/d_e_pipe_reg_pkg.sv | 47 ++++
 rtl/d_e_pipe_reg_if.sv | 41 ++++
 rtl/d_e_pipe_reg.sv | 68 ++++++
 3 files changed

// File: rtl/d_e_pipe_reg_pkg.sv
// Shared MIPS pipeline definitions: field widths, NOP and Tnew encodings,
// the saturating Tnew decrement reused by the E/M and M/W registers.
package d_e_pipe_reg_pkg;

    localparam int WORD_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int TNEW_W     = 2;

    localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;

    localparam logic [TNEW_W-1:0] TNEW_0 = 2'd0;
    localparam logic [TNEW_W-1:0] TNEW_1 = 2'd1;
    localparam logic [TNEW_W-1:0] TNEW_2 = 2'd2;

    typedef enum logic [1:0] {
        LD_RESET,
        LD_FLUSH,
        LD_BUBBLE,
        LD_NORMAL
    } load_sel_e;

    typedef struct packed {
        logic [WORD_W-1:0]     pc;
        logic [WORD_W-1:0]     instr;
        logic [WORD_W-1:0]     rd1;
        logic [WORD_W-1:0]     rd2;
        logic [WORD_W-1:0]     imm;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] a3;
        logic [TNEW_W-1:0]     tnew;
        logic                  valid;
    } de_stage_t;

    // One stage older means one cycle closer to ready; never below zero.
    function automatic logic [TNEW_W-1:0] tnew_sat_dec(input logic [TNEW_W-1:0] t);
        return (t == TNEW_0) ? TNEW_0 : t - TNEW_1;
    endfunction

    function automatic de_stage_t bubble_stage(input logic [WORD_W-1:0] nop);
        de_stage_t s;
        s       = '0;
        s.instr = nop;
        return s;
    endfunction

endpackage

// File: rtl/d_e_pipe_reg_if.sv
// D-side inputs and E-side outputs of the D/E pipeline register.
interface d_e_pipe_reg_if #(parameter int CNT_W = 32);
    import d_e_pipe_reg_pkg::*;

    logic [WORD_W-1:0]     pc_d;
    logic [WORD_W-1:0]     instr_d;
    logic [WORD_W-1:0]     rd1_d;
    logic [WORD_W-1:0]     rd2_d;
    logic [WORD_W-1:0]     imm_d;
    logic [REG_ADDR_W-1:0] rs_d;
    logic [REG_ADDR_W-1:0] rt_d;
    logic [REG_ADDR_W-1:0] a3_d;
    logic [TNEW_W-1:0]     tnew_d;

    logic [WORD_W-1:0]     pc_e;
    logic [WORD_W-1:0]     instr_e;
    logic [WORD_W-1:0]     rd1_e;
    logic [WORD_W-1:0]     rd2_e;
    logic [WORD_W-1:0]     imm_e;
    logic [REG_ADDR_W-1:0] rs_e;
    logic [REG_ADDR_W-1:0] rt_e;
    logic [REG_ADDR_W-1:0] a3_e;
    logic [TNEW_W-1:0]     tnew_e;
    logic                  valid_e;
    logic [CNT_W-1:0]      bubble_cnt;

    // D stage / bench side
    modport master (
        output pc_d, instr_d, rd1_d, rd2_d, imm_d, rs_d, rt_d, a3_d, tnew_d,
        input  pc_e, instr_e, rd1_e, rd2_e, imm_e, rs_e, rt_e, a3_e, tnew_e,
        input  valid_e, bubble_cnt
    );

    // Pipeline register side
    modport slave (
        input  pc_d, instr_d, rd1_d, rd2_d, imm_d, rs_d, rt_d, a3_d, tnew_d,
        output pc_e, instr_e, rd1_e, rd2_e, imm_e, rs_e, rt_e, a3_e, tnew_e,
        output valid_e, bubble_cnt
    );

endinterface

// File: rtl/d_e_pipe_reg.sv
// D/E pipeline register: one-cycle registered D->E transfer, bubble on stall,
// clear on flush; never holds, upstream F/D keeps the stalled instruction.
module d_e_pipe_reg
    import d_e_pipe_reg_pkg::*;
#(
    parameter int                CNT_W     = 32,
    parameter logic [WORD_W-1:0] NOP_INSTR = NOP_WORD
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           stall,
    input  logic           flush,
    d_e_pipe_reg_if.slave  bus
);

    de_stage_t        stage_q, stage_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    load_sel_e        load_sel;

    always_comb begin
        if (reset)      load_sel = LD_RESET;
        else if (flush) load_sel = LD_FLUSH;
        else if (stall) load_sel = LD_BUBBLE;
        else            load_sel = LD_NORMAL;
    end

    always_comb begin
        stage_d      = bubble_stage(NOP_INSTR);
        bubble_cnt_d = bubble_cnt_q;
        case (load_sel)
            LD_RESET:  bubble_cnt_d = '0;
            LD_FLUSH:  ;
            // Only hazard bubbles are counted; flushes are redirects, not stalls.
            LD_BUBBLE: bubble_cnt_d = bubble_cnt_q + 1'b1;
            LD_NORMAL: begin
                stage_d.pc    = bus.pc_d;
                stage_d.instr = bus.instr_d;
                stage_d.rd1   = bus.rd1_d;
                stage_d.rd2   = bus.rd2_d;
                stage_d.imm   = bus.imm_d;
                stage_d.rs    = bus.rs_d;
                stage_d.rt    = bus.rt_d;
                stage_d.a3    = bus.a3_d;
                stage_d.tnew  = tnew_sat_dec(bus.tnew_d);
                stage_d.valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        stage_q      <= stage_d;
        bubble_cnt_q <= bubble_cnt_d;
    end

    assign bus.pc_e       = stage_q.pc;
    assign bus.instr_e    = stage_q.instr;
    assign bus.rd1_e      = stage_q.rd1;
    assign bus.rd2_e      = stage_q.rd2;
    assign bus.imm_e      = stage_q.imm;
    assign bus.rs_e       = stage_q.rs;
    assign bus.rt_e       = stage_q.rt;
    assign bus.a3_e       = stage_q.a3;
    assign bus.tnew_e     = stage_q.tnew;
    assign bus.valid_e    = stage_q.valid;
    assign bus.bubble_cnt = bubble_cnt_q;

endmodule
